load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Execute-side responder to the decoder's mem_read_control / mem_write_control / funct3 outputs.
- Takes one load or store per handshake, runs a single-outstanding transaction on a word-wide data-memory bus, and returns aligned, sign/zero-extended load data or a store acknowledge.
- Sits between the execute stage and data memory; stalls the core via in_ready while busy.

Parameters:
- ADDR_W, 32, byte-address width of the request and bus address.
- DATA_W, 32, data width; fixed at 32, so strobes are 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit idle, can accept.
- mem_read  in  1  load request (from decoder).
- mem_write  in  1  store request (from decoder).
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  byte address.
- store_data  in  DATA_W  rs2 value.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: illegal or misaligned request.
- load_data  out  DATA_W  extended load result, valid with resp_valid.
- bus_req  out  1  bus request, held until bus_gnt.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- bus_wdata  out  DATA_W  lane-replicated store data.
- bus_wstrb  out  4  byte enables.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data / write ack, strictly after the gnt cycle.
- bus_rdata  in  DATA_W  read word.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except in_ready=1.
- Reset mid-transaction abandons it: bus_req drops immediately and no response is issued.
- FSM:
  - IDLE: in_ready=1. Accept on in_valid. Capture request into registers.
    - mem_read^mem_write with legal funct3 (and aligned, see option) -> REQ.
    - Both read and write set, illegal funct3 (load 011/110/111; store >010), or misaligned -> ERR.
    - in_valid with neither read nor write: ignored, stay IDLE, no response.
  - REQ: bus_req=1, bus_we/addr/wdata/wstrb stable until bus_gnt; on gnt -> WAIT.
  - WAIT: bus_req=0; on bus_rvalid capture rdata -> DONE.
  - DONE: resp_valid=1, resp_err=0, load_data valid (0 for stores) -> IDLE.
  - ERR: resp_valid=1, resp_err=1, load_data=0, no bus activity -> IDLE.
- in_ready=0 in every state except IDLE; new requests cannot be accepted in the DONE/ERR cycle.
- Latency:
  - Accept at T; bus_req from T+1; gnt at G; rvalid at R>G; resp_valid at R+1.
  - With gnt at T+1 and rvalid at T+2, resp_valid is at T+3.
  - Error path: resp_valid at T+1.
- Store lanes:
  - SB: wstrb=4'b0001<<addr[1:0], wdata={4{sd[7:0]}}.
  - SH: wstrb=4'b0011<<{addr[1],1'b0}, wdata={2{sd[15:0]}}.
  - SW: 4'b1111, wdata=sd.
- Load extract: select byte at addr[1:0] or half at addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through. Loads drive wstrb=0.
- bus_rvalid outside WAIT and bus_gnt outside REQ are ignored.
- Outputs are registered; no combinational path from in_* to bus_*.

Optional Feature:
- LSU_MISALIGN_CHECK_EN
  - Defined: H/HU with addr[0]=1, or W with addr[1:0]!=0 -> ERR path, no bus transaction.
  - Undefined: no misalign error. Offending low address bits are treated as 0: half uses addr[1], word uses lane 0.

Decomposition:
- Package riscv_lsu_pkg:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State enum IDLE/REQ/WAIT/DONE/ERR.
  - Strobe constants.
- Sub-module lsu_load_align: combinational (rdata, addr[1:0], funct3) -> load_data. Reused by a future cache path.

Test Plan:
- LW: addr=0x100, gnt at T+1, rvalid at T+2 with rdata=0xDEADBEEF -> bus_addr=0x100, wstrb=0, resp_valid at T+3, load_data=0xDEADBEEF, err=0.
- LB/LBU: addr=0x103, rdata=0x80FF_0000 -> LB returns 0xFFFFFF80, LBU returns 0x00000080; LH at 0x102 returns 0xFFFF80FF.
- SB: addr=0x201, sd=0x000000A5 -> bus_we=1, bus_addr=0x200, wstrb=4'b0010, wdata=0xA5A5A5A5; SH at 0x202, sd=0x1234 -> wstrb=4'b1100, wdata=0x12341234.
- Stall: bus_gnt low 5 cycles -> bus_req and bus fields stable, in_ready=0 throughout; rvalid asserted in the gnt cycle is ignored.
- Errors: mem_read=mem_write=1, or load funct3=011 -> resp_valid+resp_err at T+1, bus_req never asserted. With LSU_MISALIGN_CHECK_EN, LW at 0x102 -> err; without it -> bus_addr=0x100 and normal completion.
- Reset: rst_n low during WAIT -> outputs 0 and in_ready=1 asynchronously; late rvalid after release -> no resp_valid.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 encodings, FSM states, byte strobes.
// Pure declarations; no logic, no latency, no flow control.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } lsu_state_e;

  // Request attributes that must survive until the bus response returns.
  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } lsu_ctl_t;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 <= F3_SW);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it per funct3.
// Purely combinational, zero latency; no flow control.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata[{addr_lo, 3'b000} +: 8];
    // Half select ignores addr_lo[0], so an unaligned half degrades to the aligned one.
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'd0, byte_sel};
      F3_LHU:  load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store engine on a word bus; response 1 cycle after rvalid, error response 1 cycle after accept.
// in_ready low whenever not IDLE; bus_req held until bus_gnt. Optional LSU_MISALIGN_CHECK_EN flags unaligned H/W accesses.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] load_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  lsu_state_e        state_q, state_d;
  lsu_ctl_t          ctl_q, ctl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic [DATA_W-1:0] aligned;

  logic is_load, is_store, f3_ok, misalign, bad_req;

  lsu_load_align u_align (
    .rdata     (bus_rdata),
    .addr_lo   (ctl_q.addr_lo),
    .funct3    (ctl_q.funct3),
    .load_data (aligned)
  );

  always_comb begin
    is_load  = mem_read & ~mem_write;
    is_store = mem_write & ~mem_read;
    f3_ok    = is_load ? load_f3_legal(funct3) : store_f3_legal(funct3);
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
               ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    // Both read and write set also lands here: f3_ok is irrelevant then.
    bad_req  = !(is_load || is_store) || !f3_ok || misalign;
  end

  always_comb begin
    state_d     = state_q;
    ctl_d       = ctl_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    load_data_d = load_data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && (mem_read || mem_write)) begin
          load_data_d = '0;
          if (bad_req) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            ctl_d   = '{we: is_store, funct3: funct3, addr_lo: addr[1:0]};
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            wstrb_d = STRB_NONE;
            wdata_d = '0;
            if (is_store) begin
              case (funct3[1:0])
                2'b00: begin
                  wstrb_d = STRB_B << addr[1:0];
                  wdata_d = {4{store_data[7:0]}};
                end
                2'b01: begin
                  wstrb_d = STRB_H << {addr[1], 1'b0};
                  wdata_d = {2{store_data[15:0]}};
                end
                default: begin
                  wstrb_d = STRB_W;
                  wdata_d = store_data;
                end
              endcase
            end
          end
        end
      end
      REQ:  if (bus_gnt) state_d = WAIT;
      WAIT: begin
        if (bus_rvalid) begin
          state_d     = DONE;
          load_data_d = ctl_q.we ? '0 : aligned;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctl_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ctl_q       <= ctl_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      load_data_q <= load_data_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign bus_req    = (state_q == REQ);
  assign bus_we     = ctl_q.we;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign bus_wstrb  = wstrb_q;
  assign resp_valid = (state_q == DONE) || (state_q == ERR);
  assign resp_err   = (state_q == ERR);
  assign load_data  = load_data_q;

endmodule
